// File: rtl/mem_bus_responder_pkg.sv
// Shared types for the data-memory bus responder: FSM state encoding and latched request record.
package MemBusStruct;

  localparam int unsigned WORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } MemRespState;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic        is_write;
  } MemReq;

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port 64-bit word RAM with byte-masked write and registered read-before-write output.
module mem_resp_sram
  import MemBusStruct::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned IDX_W       = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic             rd_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       wmask_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(WORD_BYTES); b++) begin
      if (en_i && wmask_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register samples the old word on the same edge a write lands.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata_q <= 64'h0;
    end else if (en_i && rd_i) begin
      rdata_q <= clr_i ? 64'h0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Data-memory bus slave: stalls the core for LATENCY cycles per access, then completes it on the RAM.
// Optional MEM_RESP_RANGE_CHECK_EN: out-of-window accesses are suppressed and flagged on bus_err.
module mem_bus_responder
  import MemBusStruct::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] address2,
  input  logic        we_mem,
  input  logic        re_mem,
  input  logic [63:0] wdata_mem,
  input  logic [7:0]  wmask_mem,
  output logic [63:0] rdata_mem,
  output logic        mem_stall,
  output logic        bus_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  MemRespState      state_q;
  MemReq            req_q;
  logic             rd_q;
  logic [3:0]       cnt_q;
  logic             stall_q;
  logic             req_v;
  logic             complete;
  logic [63:0]      off;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             sram_en;
  logic [7:0]       sram_wmask;
  logic             sram_clr;
  logic             unused_off;

  assign req_v    = re_mem | we_mem;
  assign complete = (state_q == BUSY) && (cnt_q == 4'd0);
  assign off      = req_q.addr - BASE_ADDR;
  assign idx      = off[IDX_W+2:3];

`ifdef MEM_RESP_RANGE_CHECK_EN
  assign in_range   = (off >> (IDX_W + 3)) == 64'd0;
  assign unused_off = ^off[2:0];
`else
  assign in_range   = 1'b1;
  assign unused_off = ^{off[63:IDX_W+3], off[2:0]};
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (req_v) begin
            req_q.addr     <= address2;
            req_q.wdata    <= wdata_mem;
            req_q.wmask    <= wmask_mem;
            req_q.is_write <= we_mem;
            rd_q           <= re_mem;
            cnt_q          <= 4'(LATENCY - 1);
            stall_q        <= 1'b1;
            state_q        <= BUSY;
          end else begin
            stall_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        BUSY: begin
          // Requests arriving here are dropped; the latched one runs to completion.
          if (cnt_q == 4'd0) begin
            stall_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_RESP_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if ((complete && !in_range) || ((state_q == BUSY) && req_v)) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Gating with rstn discards a write whose completion edge coincides with reset.
  assign sram_en    = rstn && complete;
  assign sram_wmask = (req_q.is_write && in_range) ? req_q.wmask : 8'h00;
  assign sram_clr   = !in_range;

  mem_resp_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (sram_en),
    .rd_i   (rd_q),
    .clr_i  (sram_clr),
    .idx_i  (idx),
    .wmask_i(sram_wmask),
    .wdata_i(req_q.wdata),
    .rdata_o(rdata_mem)
  );

  assign mem_stall = stall_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with a cycle-level transaction model and literal spot checks.
module tb_mem_bus_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h0;

  logic        clk;
  logic        rstn;
  logic [63:0] address2;
  logic        we_mem;
  logic        re_mem;
  logic [63:0] wdata_mem;
  logic [7:0]  wmask_mem;
  logic [63:0] rdata_mem;
  logic        mem_stall;
  logic        bus_err;

  int total;
  int bad;

  mem_bus_responder #(
    .LATENCY    (LAT),
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .address2 (address2),
    .we_mem   (we_mem),
    .re_mem   (re_mem),
    .wdata_mem(wdata_mem),
    .wmask_mem(wmask_mem),
    .rdata_mem(rdata_mem),
    .mem_stall(mem_stall),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request completes LAT edges later; nothing is accepted meanwhile.
  logic [63:0] mm [DEPTH];
  bit          pend;
  int          cyc;
  int          done_cyc;
  logic [63:0] p_addr, p_wdata;
  logic [7:0]  p_mask;
  bit          p_re, p_we;
  logic [63:0] m_rdata;
  bit          m_err;
  bit          check_range;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mm[i] = 64'h0;
`ifdef MEM_RESP_RANGE_CHECK_EN
    check_range = 1'b1;
`else
    check_range = 1'b0;
`endif
    pend = 0; cyc = 0; done_cyc = 0; m_rdata = 64'h0; m_err = 0;
  end

  always @(posedge clk) begin
    if (!rstn) begin
      pend    = 0;
      m_rdata = 64'h0;
      m_err   = 0;
    end else if (pend) begin
      if (check_range && (re_mem || we_mem)) m_err = 1;
      if (cyc == done_cyc) begin
        logic [63:0] o;
        int          ix;
        bit          inr;
        o   = p_addr - BASE;
        ix  = int'((o >> 3) % DEPTH);
        inr = !check_range || (o < 64'(8 * DEPTH));
        if (p_re) m_rdata = inr ? mm[ix] : 64'h0;
        if (p_we && inr) begin
          for (int b = 0; b < 8; b++)
            if (p_mask[b]) mm[ix][8*b +: 8] = p_wdata[8*b +: 8];
        end
        if (!inr) m_err = 1;
        pend = 0;
      end
    end else if (re_mem || we_mem) begin
      pend     = 1;
      done_cyc = cyc + int'(LAT);
      p_addr   = address2;
      p_wdata  = wdata_mem;
      p_mask   = wmask_mem;
      p_re     = re_mem;
      p_we     = we_mem;
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("stall", {63'h0, mem_stall}, {63'h0, pend});
    chk("rdata", rdata_mem, m_rdata);
    chk("bus_err", {63'h0, bus_err}, {63'h0, m_err});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle request pulse starting at the current negedge.
  task automatic pulse(input bit re, input bit we, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    re_mem = re; we_mem = we; address2 = a; wdata_mem = d; wmask_mem = m;
    step(1);
    re_mem = 0; we_mem = 0;
  endtask

  task automatic access(input bit re, input bit we, input logic [63:0] a,
                        input logic [63:0] d, input logic [7:0] m);
    pulse(re, we, a, d, m);
    step(LAT + 1);
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 0; re_mem = 0; we_mem = 0; address2 = 0; wdata_mem = 0; wmask_mem = 0;
    step(3);
    chk("reset_stall", {63'h0, mem_stall}, 64'h0);
    chk("reset_rdata", rdata_mem, 64'h0);
    chk("reset_err", {63'h0, bus_err}, 64'h0);
    rstn = 1;
    step(1);

    // Full write then read with explicit stall profile.
    access(0, 1, 64'h100, 64'h1122334455667788, 8'hFF);
    pulse(1, 0, 64'h100, 64'h0, 8'h00);
    chk("t1_stall_c1", {63'h0, mem_stall}, 64'h1);
    step(1);
    chk("t1_stall_c2", {63'h0, mem_stall}, 64'h1);
    step(1);
    chk("t1_stall_low", {63'h0, mem_stall}, 64'h0);
    chk("t1_rdata", rdata_mem, 64'h1122334455667788);
    chk("t1_model", m_rdata, 64'h1122334455667788);
    step(1);

    // Partial-mask write.
    access(0, 1, 64'h100, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    access(1, 0, 64'h104, 64'h0, 8'h00);
    chk("t2_rdata", rdata_mem, 64'h11223344BBBBBBBB);

    // Empty mask write is a no-op.
    access(0, 1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    access(1, 0, 64'h100, 64'h0, 8'h00);
    chk("mask0_rdata", rdata_mem, 64'h11223344BBBBBBBB);

    // Back-to-back: second read issued in the DONE cycle.
    access(0, 1, 64'h108, 64'hCAFE_F00D_1234_5678, 8'hFF);
    pulse(1, 0, 64'h100, 64'h0, 8'h00);
    step(LAT);
    chk("t3_done_low", {63'h0, mem_stall}, 64'h0);
    pulse(1, 0, 64'h108, 64'h0, 8'h00);
    chk("t3_restall", {63'h0, mem_stall}, 64'h1);
    step(LAT);
    chk("t3_rdata", rdata_mem, 64'hCAFE_F00D_1234_5678);
    step(1);

    // Pulse during BUSY is ignored.
    pulse(1, 0, 64'h100, 64'h0, 8'h00);
    pulse(1, 0, 64'h108, 64'h0, 8'h00);
    step(LAT + 2);
    chk("t4_rdata", rdata_mem, 64'h11223344BBBBBBBB);
    chk("t4_idle", {63'h0, mem_stall}, 64'h0);

    // Read and write together: returns the pre-write word.
    access(1, 1, 64'h108, 64'h0102_0304_0506_0708, 8'hFF);
    chk("rw_rdata", rdata_mem, 64'hCAFE_F00D_1234_5678);
    access(1, 0, 64'h108, 64'h0, 8'h00);
    chk("rw_after", rdata_mem, 64'h0102_0304_0506_0708);

    // Reset in the middle of a write aborts it.
    access(0, 1, 64'h200, 64'h5555_6666_7777_8888, 8'hFF);
    pulse(0, 1, 64'h200, 64'h9999_9999_9999_9999, 8'hFF);
    rstn = 0;
    step(1);
    chk("t5_abort_stall", {63'h0, mem_stall}, 64'h0);
    rstn = 1;
    step(LAT + 1);
    access(1, 0, 64'h200, 64'h0, 8'h00);
    chk("t5_rdata", rdata_mem, 64'h5555_6666_7777_8888);

    // Address one past the end of the window.
    access(0, 1, 64'h8000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    access(1, 0, 64'h8000, 64'h0, 8'h00);
`ifdef MEM_RESP_RANGE_CHECK_EN
    chk("t6_rdata", rdata_mem, 64'h0);
    chk("t6_err", {63'h0, bus_err}, 64'h1);
`else
    chk("t6_rdata", rdata_mem, 64'hDEAD_BEEF_0BAD_F00D);
    access(1, 0, 64'h0, 64'h0, 8'h00);
    chk("t6_alias", rdata_mem, 64'hDEAD_BEEF_0BAD_F00D);
    chk("t6_err", {63'h0, bus_err}, 64'h0);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
